button_conditioner: RTL and testbench

Conditions the raw, asynchronous pushbutton into the clean `P1` input consumed by the downstream `moore_machine` sequence detector. Synchronizes the button to `clk`, debounces it with a cycle-count filter, and emits exactly one single-cycle `P1` pulse per accepted press, so that one press is one input symbol. It also exports the debounced level for LEDs and debug.

---
 rtl/btn_cond_pkg.sv | 21 ++
 rtl/btn_sync.sv | 24 ++
 rtl/button_conditioner.sv | 122 ++++++++++++
 tb/tb_button_conditioner.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
// Holds the debounce FSM states and the default parameter values.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_COUNT_W         = 8;

  // A one-cycle debounce still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Flip-flop chain that brings the raw button into the clk domain.
// All stages clear on synchronous active-low reset.
module btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Sync + debounce a pushbutton; one P1 pulse per accepted press.
// Define BTN_PRESS_COUNT_EN to add the press_count output.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int COUNT_W         = DEF_COUNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic P1
`ifdef BTN_PRESS_COUNT_EN
  ,
  output logic [COUNT_W-1:0] press_count
`endif
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_s;
  btn_state_t       r_state;
  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_p1;
  logic             w_p1_nxt;

  btn_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (btn_in),
    .o_q  (w_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_p1    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_p1    <= w_p1_nxt;
    end
  end

  // P1 defaults low so it can never outlive one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_p1_nxt    = 1'b0;
    unique case (r_state)
      IDLE_LOW: begin
        if (w_s) begin
          w_state_nxt = CHECK_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!w_s) begin
          w_state_nxt = IDLE_LOW;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE_HIGH;
          w_level_nxt = 1'b1;
          w_p1_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!w_s) begin
          w_state_nxt = CHECK_LOW;
          w_cnt_nxt   = '0;
        end
      end
      CHECK_LOW: begin
        if (w_s) begin
          w_state_nxt = IDLE_HIGH;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE_LOW;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign level = r_level;
  assign P1    = r_p1;

`ifdef BTN_PRESS_COUNT_EN
  logic [COUNT_W-1:0] r_press_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_press_count <= '0;
    end else if (w_p1_nxt) begin
      r_press_count <= r_press_count + 1'b1;
    end
  end

  assign press_count = r_press_count;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Table-driven bench for button_conditioner (D=4, S=2, W=3).
// Expected outputs are queued at drive time and popped after the edge.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int S = 2;
  localparam int W = 3;

  typedef struct {
    logic           rst_n;
    logic           btn;
    logic           lvl;
    logic           p1;
    logic [W-1:0]   cnt;
    int             sc;
  } vec_t;

  logic clk;
  logic reset;
  logic btn_in;
  logic level;
  logic P1;
  logic [W-1:0] press_count;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks;
  int   n_pass;
  int   cur_sc;
  logic [W-1:0] m_cnt;
  int   exp_pulses;
  int   seen_pulses;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S),
    .COUNT_W        (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_in(btn_in),
    .level (level),
    .P1    (P1)
`ifdef BTN_PRESS_COUNT_EN
    ,
    .press_count(press_count)
`endif
  );

`ifndef BTN_PRESS_COUNT_EN
  assign press_count = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic b,
                              input logic l, input logic p,
                              input int n);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      if (!r) m_cnt = '0;
      else if (p) m_cnt = m_cnt + 1'b1;
      if (p) exp_pulses++;
      v.rst_n = r;
      v.btn   = b;
      v.lvl   = l;
      v.p1    = p;
      v.cnt   = m_cnt;
      v.sc    = cur_sc;
      vecs.push_back(v);
    end
  endfunction

  // Edge 0 samples btn=1; pulse and level rise after edge S+D.
  function automatic void add_press(input int n_after);
    add(1, 1, 0, 0, S + D);
    add(1, 1, 1, 1, 1);
    add(1, 1, 1, 0, n_after);
  endfunction

  function automatic void add_release(input int n_after);
    add(1, 0, 1, 0, S + D);
    add(1, 0, 0, 0, 1);
    add(1, 0, 0, 0, n_after);
  endfunction

  initial begin
    logic [5:0] pat;
    vec_t e;
    logic ok;
    n_checks    = 0;
    n_pass      = 0;
    m_cnt       = '0;
    exp_pulses  = 0;
    seen_pulses = 0;
    reset       = 1'b0;
    btn_in      = 1'b0;

    cur_sc = 0;
    add(0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 3);
    cur_sc = 1;
    add_press(13);
    cur_sc = 2;
    add_release(3);
    cur_sc = 3;
    add(1, 1, 0, 0, 2);
    add(1, 0, 0, 0, 2);
    add(1, 1, 0, 0, 2);
    add(1, 0, 0, 0, 2);
    add_press(3);
    add_release(3);
    cur_sc = 4;
    add(1, 1, 0, 0, 4);
    add(0, 1, 0, 0, 2);
    add_press(3);
    add_release(3);
    cur_sc = 5;
    add(0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 2);
    for (int k = 0; k < 8; k++) begin
      add_press(1);
      add_release(1);
    end
    cur_sc = 6;
    pat = 6'b011011;
    for (int k = 5; k >= 0; k--) begin
      if (pat[k]) begin
        add_press(1);
        add_release(1);
      end else begin
        add(1, 0, 0, 0, 16);
      end
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset  = vecs[i].rst_n;
      btn_in = vecs[i].btn;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (P1 === 1'b1) seen_pulses++;
      ok = (level === e.lvl) && (P1 === e.p1);
`ifdef BTN_PRESS_COUNT_EN
      ok = ok && (press_count === e.cnt);
`endif
      n_checks++;
      if (ok) begin
        n_pass++;
      end else begin
        $display("FAIL sc%0d row%0d: level=%b P1=%b cnt=%0d, want level=%b P1=%b cnt=%0d",
                 e.sc, i, level, P1, press_count, e.lvl, e.p1, e.cnt);
      end
    end

    n_checks++;
    if (seen_pulses == exp_pulses) begin
      n_pass++;
    end else begin
      $display("FAIL pulse_total: got %0d, want %0d",
               seen_pulses, exp_pulses);
    end

    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
